// File: rtl/lcd1602_drv.sv
// Write-only HD44780 16x2 driver, 8-bit bus: power-on init, then continuous refresh of both
// lines from a per-frame snapshot of the producer-filled character buffer.
package lcd_t;
  typedef struct packed {
    logic [0:31][7:0] mem;
  } lcd_1602;
endpackage

module lcd1602_drv #(
  parameter int unsigned T_PWR  = 1_000_000,
  parameter int unsigned T_AS   = 4,
  parameter int unsigned T_PW   = 25,
  parameter int unsigned T_INIT = 250_000,
  parameter int unsigned T_CMD  = 2_500,
  parameter int unsigned T_CLR  = 100_000
) (
  input  logic            clk,
  input  logic            rst,
  input  lcd_t::lcd_1602  in_lcd,
  output logic            lcd_rs,
  output logic            lcd_rw,
  output logic            lcd_e,
  output logic [7:0]      lcd_db,
  output logic            init_done,
  output logic            frame_done
);

  typedef enum logic [1:0] {PWR_WAIT, INIT, FRAME} state_t;
  typedef enum logic [1:0] {SETUP, E_HI, WAIT} phase_t;

  state_t           state, state_n;
  phase_t           phase, phase_n;
  logic [31:0]      cnt, cnt_n, cnt_inc, wait_len;
  logic [5:0]       idx, idx_n;
  logic [4:0]       sidx;
  logic [0:31][7:0] shadow;
  logic             snap, init_done_n, frame_done_n, rs_n, e_n;
  logic [7:0]       db_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= PWR_WAIT;
      phase      <= SETUP;
      cnt        <= '0;
      idx        <= '0;
      lcd_e      <= 1'b0;
      lcd_rs     <= 1'b0;
      lcd_rw     <= 1'b0;
      lcd_db     <= '0;
      init_done  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      phase      <= phase_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      lcd_e      <= e_n;
      lcd_rs     <= rs_n;
      lcd_rw     <= 1'b0;
      lcd_db     <= db_n;
      init_done  <= init_done_n;
      frame_done <= frame_done_n;
    end
  end

  // Snapshot taken on the edge that enters the 0x80 command's SETUP, so a whole frame is coherent.
  always_ff @(posedge clk) begin
    if (!rst && snap) shadow <= in_lcd.mem;
  end

  always_comb begin
    wait_len = T_CMD;
    if (state == INIT) begin
      case (idx)
        6'd0:    wait_len = T_INIT;
        6'd4:    wait_len = T_CLR;
        default: wait_len = T_CMD;
      endcase
    end
  end

  always_comb begin
    state_n      = state;
    phase_n      = phase;
    cnt_inc      = cnt + 32'd1;
    cnt_n        = cnt_inc;
    idx_n        = idx;
    snap         = 1'b0;
    init_done_n  = init_done;
    frame_done_n = 1'b0;

    case (state)
      PWR_WAIT: begin
        if (cnt_inc == T_PWR) begin
          state_n = INIT;
          phase_n = SETUP;
          cnt_n   = '0;
          idx_n   = '0;
        end
      end
      default: begin
        case (phase)
          SETUP: begin
            if (cnt_inc == T_AS) begin
              phase_n = E_HI;
              cnt_n   = '0;
            end
          end
          E_HI: begin
            if (cnt_inc == T_PW) begin
              phase_n = WAIT;
              cnt_n   = '0;
            end
          end
          default: begin
            if (cnt_inc == wait_len) begin
              phase_n = SETUP;
              cnt_n   = '0;
              if (state == INIT) begin
                if (idx == 6'd5) begin
                  state_n     = FRAME;
                  idx_n       = '0;
                  snap        = 1'b1;
                  init_done_n = 1'b1;
                end else begin
                  idx_n = idx + 6'd1;
                end
              end else begin
                if (idx == 6'd33) begin
                  idx_n        = '0;
                  snap         = 1'b1;
                  frame_done_n = 1'b1;
                end else begin
                  idx_n = idx + 6'd1;
                end
              end
            end
          end
        endcase
      end
    endcase
  end

  // Bus values follow the next-state index so they are registered and stable per transaction.
  always_comb begin
    e_n  = (state_n != PWR_WAIT) && (phase_n == E_HI);
    rs_n = lcd_rs;
    db_n = lcd_db;
    sidx = '0;
    if (state_n == INIT) begin
      rs_n = 1'b0;
      case (idx_n)
        6'd0, 6'd1, 6'd2: db_n = 8'h38;
        6'd3:             db_n = 8'h0C;
        6'd4:             db_n = 8'h01;
        default:          db_n = 8'h06;
      endcase
    end else if (state_n == FRAME) begin
      if (idx_n == 6'd0) begin
        rs_n = 1'b0;
        db_n = 8'h80;
      end else if (idx_n == 6'd17) begin
        rs_n = 1'b0;
        db_n = 8'hC0;
      end else begin
        rs_n = 1'b1;
        sidx = idx_n[4:0] - ((idx_n < 6'd17) ? 5'd1 : 5'd2);
        db_n = shadow[sidx];
      end
    end
  end

endmodule

// File: tb/tb_lcd1602_drv.sv
// Directed bench for lcd1602_drv: init sequence, frame content, snapshot behaviour,
// mid-operation reset and per-pulse bus timing.
module tb_lcd1602_drv;

  localparam int unsigned P_PWR = 100, P_AS = 2, P_PW = 3, P_INIT = 50, P_CMD = 10, P_CLR = 40;
  localparam int FRAME_CYC = 34 * (P_AS + P_PW + P_CMD);

  logic           clk = 1'b0;
  logic           rst;
  lcd_t::lcd_1602 in_lcd;
  logic           lcd_rs, lcd_rw, lcd_e, init_done, frame_done;
  logic [7:0]     lcd_db;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic       mon_en = 1'b0;
  logic [8:0] bus_prev;
  logic       e_prev, fd_prev;
  int         chg_cyc, rise_cyc, fall_cyc, fd_cyc, fd_cnt;
  bit         have_fall, have_fd;
  int         rise_q[$];
  logic [7:0] db_q[$];
  logic       rs_q[$];

  lcd1602_drv #(
    .T_PWR(P_PWR), .T_AS(P_AS), .T_PW(P_PW), .T_INIT(P_INIT), .T_CMD(P_CMD), .T_CLR(P_CLR)
  ) dut (
    .clk(clk), .rst(rst), .in_lcd(in_lcd),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_db(lcd_db),
    .init_done(init_done), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Pulse monitor: records every E rise and checks timing/stability of each transaction.
  always @(negedge clk) begin
    if (!mon_en) begin
      bus_prev  = {lcd_rs, lcd_db};
      e_prev    = lcd_e;
      fd_prev   = frame_done;
      chg_cyc   = cyc;
      have_fall = 0;
      have_fd   = 0;
      fd_cnt    = 0;
    end else begin
      if ({lcd_rs, lcd_db} != bus_prev) begin
        check("bus_chg_e_low", {31'd0, lcd_e}, 32'd0);
        if (have_fall) check("bus_chg_after_wait", {31'd0, (cyc - fall_cyc) >= int'(P_CMD)}, 32'd1);
        chg_cyc = cyc;
      end
      if (lcd_e && !e_prev) begin
        check("setup_time", {31'd0, (cyc - chg_cyc) >= int'(P_AS)}, 32'd1);
        check("rw_low", {31'd0, lcd_rw}, 32'd0);
        rise_cyc = cyc;
        rise_q.push_back(cyc);
        db_q.push_back(lcd_db);
        rs_q.push_back(lcd_rs);
      end
      if (!lcd_e && e_prev) begin
        check("e_width", cyc - rise_cyc, P_PW);
        fall_cyc  = cyc;
        have_fall = 1;
      end
      if (frame_done) begin
        check("fd_width", {31'd0, fd_prev}, 32'd0);
        if (have_fd) check("frame_period", cyc - fd_cyc, FRAME_CYC);
        fd_cyc  = cyc;
        have_fd = 1;
        fd_cnt++;
      end
      bus_prev = {lcd_rs, lcd_db};
      e_prev   = lcd_e;
      fd_prev  = frame_done;
    end
  end

  task automatic get_pulse(output int rc, output logic [7:0] d, output logic r);
    int n = 0;
    while (rise_q.size() == 0 && n < 2000) begin
      @(negedge clk); #1;
      n++;
    end
    if (rise_q.size() == 0) begin
      check("pulse_timeout", 32'd0, 32'd1);
      rc = -1; d = '0; r = 1'b0;
    end else begin
      rc = rise_q.pop_front();
      d  = db_q.pop_front();
      r  = rs_q.pop_front();
    end
  endtask

  task automatic check_frame(input logic [0:31][7:0] exp, input int mod_at, input bit first);
    int rc; logic [7:0] d, ed; logic r, er;
    for (int i = 0; i < 34; i++) begin
      get_pulse(rc, d, r);
      if (i == 0)       begin ed = 8'h80;      er = 1'b0; end
      else if (i < 17)  begin ed = exp[i - 1]; er = 1'b1; end
      else if (i == 17) begin ed = 8'hC0;      er = 1'b0; end
      else              begin ed = exp[i - 2]; er = 1'b1; end
      check($sformatf("frame_db[%0d]", i), {24'd0, d}, {24'd0, ed});
      check($sformatf("frame_rs[%0d]", i), {31'd0, r}, {31'd0, er});
      if (i == 0) begin
        if (first) check("fd_before_first", fd_cnt, 0);
        else       check("fd_align", fd_cyc, rc - int'(P_AS));
      end
      if (i == mod_at) in_lcd.mem[5] = 8'h5A;
    end
  endtask

  initial begin
    logic [0:31][7:0] exp0, exp1, exp2;
    logic [7:0] init_db[6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    int gaps[5] = '{55, 15, 15, 15, 45};
    int rc, prev, n;
    logic [7:0] d;
    logic r;

    exp0 = {"0123456789ABCDEF", " A.0x1F3 D.0x0FF"};
    in_lcd.mem = {"0123456789ABCDEF", " A.0x1F3 D.0x0FF"};
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_e", {31'd0, lcd_e}, 32'd0);
    check("rst_rs", {31'd0, lcd_rs}, 32'd0);
    check("rst_rw", {31'd0, lcd_rw}, 32'd0);
    check("rst_db", {24'd0, lcd_db}, 32'd0);
    check("rst_init_done", {31'd0, init_done}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;

    prev = 0;
    for (int i = 0; i < 6; i++) begin
      get_pulse(rc, d, r);
      check($sformatf("init_db[%0d]", i), {24'd0, d}, {24'd0, init_db[i]});
      check($sformatf("init_rs[%0d]", i), {31'd0, r}, 32'd0);
      if (i == 0) begin
        check("first_rise_cycle", rc, P_PWR + P_AS);
        check("init_done_early", {31'd0, init_done}, 32'd0);
      end else begin
        check($sformatf("init_gap[%0d]", i), rc - prev, gaps[i - 1]);
      end
      prev = rc;
    end
    n = 0;
    while (cyc < prev + 12 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    check("init_done_last_wait", {31'd0, init_done}, 32'd0);
    @(negedge clk); #1;
    check("init_done_rise", {31'd0, init_done}, 32'd1);

    check_frame(exp0, 3, 1'b1);
    exp1 = exp0;
    exp1[5] = 8'h5A;
    check_frame(exp1, -1, 1'b0);
    in_lcd.mem[16] = 8'h00;
    in_lcd.mem[31] = 8'h1F;
    exp2 = exp1;
    exp2[16] = 8'h00;
    exp2[31] = 8'h1F;
    check_frame(exp2, -1, 1'b0);

    get_pulse(rc, d, r);
    check("e_high_before_rst", {31'd0, lcd_e}, 32'd1);
    mon_en = 1'b0;
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    check("midrst_e", {31'd0, lcd_e}, 32'd0);
    check("midrst_init_done", {31'd0, init_done}, 32'd0);
    check("midrst_frame_done", {31'd0, frame_done}, 32'd0);
    check("midrst_db", {24'd0, lcd_db}, 32'd0);
    rise_q.delete();
    db_q.delete();
    rs_q.delete();
    mon_en = 1'b1;
    get_pulse(rc, d, r);
    check("restart_rise_cycle", rc, P_PWR + P_AS);
    check("restart_db", {24'd0, d}, 32'h38);
    check("restart_rs", {31'd0, r}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
